serial_tx_arbiter: RTL



---
 rtl/serial_tx_arbiter_if.sv | 26 ++
 rtl/serial_tx_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter_if.sv
// Requester / transmitter handshake bundle for serial_tx_arbiter.
// master: the arbiter side.  slave: requesters plus transmitter.
interface serial_tx_arbiter_if;
  logic       cpu_req;
  logic [0:7] cpu_char;
  logic       cpu_ack;
  logic       mon_req;
  logic [0:7] mon_char;
  logic       mon_lock;
  logic       mon_ack;
  logic [0:7] tx_char;
  logic       tx_load;
  logic       tx_busy;
  logic       owner;
  logic       err_timeout;

  modport master (
    input  cpu_req, cpu_char, mon_req, mon_char, mon_lock, tx_busy,
    output cpu_ack, mon_ack, tx_char, tx_load, owner, err_timeout
  );

  modport slave (
    output cpu_req, cpu_char, mon_req, mon_char, mon_lock, tx_busy,
    input  cpu_ack, mon_ack, tx_char, tx_load, owner, err_timeout
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between the CPU
// teleprinter path and the monitor message source, with monitor lock,
// load-pulse sequencing, busy tracking and a busy-rise timeout.
module serial_tx_arbiter #(
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  serial_tx_arbiter_if.master  bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [0:7] tx_char_q, tx_char_d;
  logic       tx_load_q, tx_load_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       mon_ack_q, mon_ack_d;
  logic       owner_q, owner_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       grant_cpu, grant_mon;

  // Next-state, grant selection and registered-output precomputation
  always_comb begin
    state_d   = state_q;
    tx_char_d = tx_char_q;
    tx_load_d = 1'b0;
    cpu_ack_d = 1'b0;
    mon_ack_d = 1'b0;
    owner_d   = owner_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 8'd1;
    grant_cpu = 1'b0;
    grant_mon = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A held lock only counts while the monitor already owns the line.
        if (bus.mon_lock && owner_q) begin
          grant_mon = bus.mon_req;
        end else if (bus.cpu_req && bus.mon_req) begin
          grant_cpu = owner_q;
          grant_mon = ~owner_q;
        end else begin
          grant_cpu = bus.cpu_req;
          grant_mon = bus.mon_req;
        end

        if (grant_mon) begin
          tx_char_d = bus.mon_char;
          owner_d   = 1'b1;
          tx_load_d = 1'b1;
          state_d   = S_LOAD;
        end else if (grant_cpu) begin
          tx_char_d = bus.cpu_char;
          owner_d   = 1'b0;
          tx_load_d = 1'b1;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          // Abandon the transfer but still ack so the owner never hangs.
          if (cnt_inc == TIMEOUT_C) begin
            err_d     = 1'b1;
            cpu_ack_d = ~owner_q;
            mon_ack_d = owner_q;
            state_d   = S_DONE;
          end
        end
      end

      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cpu_ack_d = ~owner_q;
          mon_ack_d = owner_q;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset and clear are equivalent
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q   <= S_IDLE;
      tx_char_q <= '0;
      tx_load_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      mon_ack_q <= 1'b0;
      owner_q   <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_char_q <= tx_char_d;
      tx_load_q <= tx_load_d;
      cpu_ack_q <= cpu_ack_d;
      mon_ack_q <= mon_ack_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.tx_char     = tx_char_q;
  assign bus.tx_load     = tx_load_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.mon_ack     = mon_ack_q;
  assign bus.owner       = owner_q;
  assign bus.err_timeout = err_q;

endmodule
